// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control FSM for the RISC-V datapath.
// Sequences fetch/decode/execute/writeback, counts cycles and retired instructions.
//
// state            | meaning
// -----------------+-----------------------------------------------------------
// 1111 OCIOSO      | idle after reset, waits for iniciar
// 0000 BUSCA       | instruction fetch, IR load and PC+4
// 0001 DECODIFICA  | opcode decode, opcode latched
// 0010 EXEC_R      | R-type ALU op and writeback (final)
// 0011 CALC_END    | load/store address calculation
// 0100 LE_MEM      | data memory read
// 0101 ESCREVE_LW  | load writeback (final)
// 0110 EXEC_I      | I-type ALU op and writeback (final)
// 0111 EXEC_B      | branch compare (final)
// 1000 ESCREVE_MEM | data memory write (final)
// 1001 PARADA      | halted until reset
module controle_multiciclo #(
    parameter int NUM_INSTR    = 16,
    parameter int LARGURA_CONT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic [6:0]              opcode,
    output logic [3:0]              estado,
    output logic                    regiwrite,
    output logic                    memtoreg,
    output logic                    memread,
    output logic                    memwrite,
    output logic                    alusrc,
    output logic [1:0]              aluop,
    output logic                    irwrite,
    output logic                    pcwrite,
    output logic                    branch,
    output logic                    halt,
    output logic                    erro,
    output logic [LARGURA_CONT-1:0] ciclos,
    output logic [LARGURA_CONT-1:0] instrucoes
);

    localparam logic [3:0] BUSCA       = 4'b0000;
    localparam logic [3:0] DECODIFICA  = 4'b0001;
    localparam logic [3:0] EXEC_R      = 4'b0010;
    localparam logic [3:0] CALC_END    = 4'b0011;
    localparam logic [3:0] LE_MEM      = 4'b0100;
    localparam logic [3:0] ESCREVE_LW  = 4'b0101;
    localparam logic [3:0] EXEC_I      = 4'b0110;
    localparam logic [3:0] EXEC_B      = 4'b0111;
    localparam logic [3:0] ESCREVE_MEM = 4'b1000;
    localparam logic [3:0] PARADA      = 4'b1001;
    localparam logic [3:0] OCIOSO      = 4'b1111;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;

    localparam logic [LARGURA_CONT-1:0] CONT_UM  = {{(LARGURA_CONT-1){1'b0}}, 1'b1};
    localparam logic [LARGURA_CONT-1:0] CONT_MAX = {LARGURA_CONT{1'b1}};
    localparam logic [LARGURA_CONT-1:0] ALVO     = LARGURA_CONT'(NUM_INSTR);

    logic [3:0]              estado_q, estado_d;
    logic [6:0]              opcode_q, opcode_d;
    logic [LARGURA_CONT-1:0] ciclos_q, ciclos_d;
    logic [LARGURA_CONT-1:0] instrucoes_q, instrucoes_d;
    logic                    halt_q, halt_d;
    logic                    erro_q, erro_d;
    logic [LARGURA_CONT-1:0] instr_mais_um;
    logic                    fim_instr;

    always_comb begin
        estado_d      = estado_q;
        opcode_d      = opcode_q;
        instrucoes_d  = instrucoes_q;
        erro_d        = erro_q;
        fim_instr     = 1'b0;
        instr_mais_um = instrucoes_q + CONT_UM;

        case (estado_q)
            OCIOSO: begin
                if (iniciar) estado_d = BUSCA;
            end
            BUSCA: estado_d = DECODIFICA;
            DECODIFICA: begin
                opcode_d = opcode;
                case (opcode)
                    OP_R:         estado_d = EXEC_R;
                    OP_I:         estado_d = EXEC_I;
                    OP_LW, OP_SW: estado_d = CALC_END;
                    OP_B:         estado_d = EXEC_B;
                    default: begin
                        estado_d = PARADA;
                        erro_d   = 1'b1;
                    end
                endcase
            end
            // Only the latched opcode is trusted here; the IR may already be changing.
            CALC_END: begin
                if (opcode_q == OP_LW) begin
                    estado_d = LE_MEM;
                end else if (opcode_q == OP_SW) begin
                    estado_d = ESCREVE_MEM;
                end else begin
                    estado_d = PARADA;
                    erro_d   = 1'b1;
                end
            end
            LE_MEM: estado_d = ESCREVE_LW;
            EXEC_R, EXEC_I, ESCREVE_LW, EXEC_B, ESCREVE_MEM: fim_instr = 1'b1;
            PARADA: estado_d = PARADA;
            default: begin
                estado_d = PARADA;
                erro_d   = 1'b1;
            end
        endcase

        if (fim_instr) begin
            instrucoes_d = instr_mais_um;
            estado_d     = (instr_mais_um == ALVO) ? PARADA : BUSCA;
        end

        halt_d = (estado_d == PARADA);

        ciclos_d = ciclos_q;
        if ((estado_q != OCIOSO) && (estado_q != PARADA) && (ciclos_q != CONT_MAX)) begin
            ciclos_d = ciclos_q + CONT_UM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            opcode_q     <= 7'b0;
            ciclos_q     <= '0;
            instrucoes_q <= '0;
            halt_q       <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            opcode_q     <= opcode_d;
            ciclos_q     <= ciclos_d;
            instrucoes_q <= instrucoes_d;
            halt_q       <= halt_d;
            erro_q       <= erro_d;
        end
    end

    // Moore decode: outputs depend only on the registered state.
    always_comb begin
        regiwrite = 1'b0;
        memtoreg  = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        alusrc    = 1'b0;
        aluop     = 2'b00;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        branch    = 1'b0;
        case (estado_q)
            BUSCA: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            CALC_END: alusrc = 1'b1;
            LE_MEM: begin
                memread = 1'b1;
                alusrc  = 1'b1;
            end
            ESCREVE_LW: begin
                regiwrite = 1'b1;
                memtoreg  = 1'b1;
            end
            EXEC_R: begin
                regiwrite = 1'b1;
                aluop     = 2'b10;
            end
            EXEC_I: begin
                regiwrite = 1'b1;
                alusrc    = 1'b1;
                aluop     = 2'b11;
            end
            EXEC_B: begin
                branch = 1'b1;
                aluop  = 2'b01;
            end
            ESCREVE_MEM: begin
                memwrite = 1'b1;
                alusrc   = 1'b1;
            end
            default: ;
        endcase
    end

    assign estado     = estado_q;
    assign ciclos     = ciclos_q;
    assign instrucoes = instrucoes_q;
    assign halt       = halt_q;
    assign erro       = erro_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed and random programs checked against
// an instruction-level reference model; a narrow-counter copy checks saturation.
module tb_controle_multiciclo;

    localparam int NI = 3;
    localparam int W  = 16;
    localparam int WS = 3;

    localparam logic [3:0] S_BUSCA = 4'b0000, S_DEC = 4'b0001, S_R = 4'b0010,
                           S_CALC = 4'b0011, S_LE = 4'b0100, S_ELW = 4'b0101,
                           S_I = 4'b0110, S_B = 4'b0111, S_EMEM = 4'b1000,
                           S_PARADA = 4'b1001, S_OCIOSO = 4'b1111;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;

    logic clk = 1'b0;
    logic reset, iniciar;
    logic [6:0] opcode;

    logic [3:0]  a_estado, b_estado;
    logic        a_regiwrite, a_memtoreg, a_memread, a_memwrite, a_alusrc;
    logic        b_regiwrite, b_memtoreg, b_memread, b_memwrite, b_alusrc;
    logic [1:0]  a_aluop, b_aluop;
    logic        a_irwrite, a_pcwrite, a_branch, a_halt, a_erro;
    logic        b_irwrite, b_pcwrite, b_branch, b_halt, b_erro;
    logic [W-1:0]  a_ciclos, a_instrucoes;
    logic [WS-1:0] b_ciclos, b_instrucoes;

    controle_multiciclo #(.NUM_INSTR(NI), .LARGURA_CONT(W)) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .opcode(opcode),
        .estado(a_estado), .regiwrite(a_regiwrite), .memtoreg(a_memtoreg),
        .memread(a_memread), .memwrite(a_memwrite), .alusrc(a_alusrc),
        .aluop(a_aluop), .irwrite(a_irwrite), .pcwrite(a_pcwrite),
        .branch(a_branch), .halt(a_halt), .erro(a_erro),
        .ciclos(a_ciclos), .instrucoes(a_instrucoes)
    );

    controle_multiciclo #(.NUM_INSTR(NI), .LARGURA_CONT(WS)) dut_sat (
        .clk(clk), .reset(reset), .iniciar(iniciar), .opcode(opcode),
        .estado(b_estado), .regiwrite(b_regiwrite), .memtoreg(b_memtoreg),
        .memread(b_memread), .memwrite(b_memwrite), .alusrc(b_alusrc),
        .aluop(b_aluop), .irwrite(b_irwrite), .pcwrite(b_pcwrite),
        .branch(b_branch), .halt(b_halt), .erro(b_erro),
        .ciclos(b_ciclos), .instrucoes(b_instrucoes)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: instruction-level view of the machine.
    logic [3:0] cur;
    int m_cyc;
    int m_ins;
    logic m_erro;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {regiwrite, memtoreg, memread, memwrite, alusrc, aluop, irwrite, pcwrite, branch}
    function automatic logic [9:0] exp_ctrl(input logic [3:0] e);
        case (e)
            S_BUSCA: return 10'b00000_00_110;
            S_CALC:  return 10'b00001_00_000;
            S_LE:    return 10'b00101_00_000;
            S_ELW:   return 10'b11000_00_000;
            S_R:     return 10'b10000_10_000;
            S_I:     return 10'b10001_11_000;
            S_B:     return 10'b00000_01_001;
            S_EMEM:  return 10'b00011_00_000;
            default: return 10'b00000_00_000;
        endcase
    endfunction

    function automatic logic legal(input logic [6:0] o);
        return (o == OP_R) || (o == OP_I) || (o == OP_LW) || (o == OP_SW) || (o == OP_B);
    endfunction

    function automatic logic [6:0] rand_op();
        logic [6:0] o;
        case ($urandom_range(0, 7))
            0:       o = OP_R;
            1:       o = OP_I;
            2, 3:    o = OP_LW;
            4:       o = OP_SW;
            5, 6:    o = OP_B;
            default: begin
                do o = 7'($urandom); while (legal(o));
            end
        endcase
        return o;
    endfunction

    // One clock: drive inputs, advance, compare both DUTs against the model.
    task automatic step(input logic rst, input logic ini, input logic [6:0] op, input logic [3:0] nxt);
        int sat;
        reset   = rst;
        iniciar = ini;
        opcode  = op;
        @(posedge clk);
        #1;
        if (rst) begin
            m_cyc  = 0;
            m_ins  = 0;
            m_erro = 1'b0;
        end else if (cur != S_OCIOSO && cur != S_PARADA) begin
            m_cyc++;
        end
        cur = nxt;
        sat = (m_cyc > (2 ** WS - 1)) ? (2 ** WS - 1) : m_cyc;
        check("estado", 32'(a_estado), 32'(cur));
        check("ctrl", 32'({a_regiwrite, a_memtoreg, a_memread, a_memwrite, a_alusrc,
                           a_aluop, a_irwrite, a_pcwrite, a_branch}), 32'(exp_ctrl(cur)));
        check("halt", 32'(a_halt), 32'(cur == S_PARADA));
        check("erro", 32'(a_erro), 32'(m_erro));
        check("ciclos", 32'(a_ciclos), 32'(m_cyc));
        check("instrucoes", 32'(a_instrucoes), 32'(m_ins));
        check("sat_estado", 32'(b_estado), 32'(cur));
        check("sat_ciclos", 32'(b_ciclos), 32'(sat));
        check("sat_instrucoes", 32'(b_instrucoes), 32'(m_ins));
    endtask

    // Executes one instruction starting from BUSCA.
    task automatic exec_instr(input logic [6:0] op);
        logic [3:0] seq[$];
        step(1'b0, 1'($urandom), 7'($urandom), S_DEC);
        case (op)
            OP_R:    seq.push_back(S_R);
            OP_I:    seq.push_back(S_I);
            OP_B:    seq.push_back(S_B);
            OP_LW:   begin seq.push_back(S_CALC); seq.push_back(S_LE); seq.push_back(S_ELW); end
            OP_SW:   begin seq.push_back(S_CALC); seq.push_back(S_EMEM); end
            default: ;
        endcase
        if (seq.size() == 0) begin
            m_erro = 1'b1;
            step(1'b0, 1'($urandom), op, S_PARADA);
            return;
        end
        step(1'b0, 1'($urandom), op, seq[0]);
        for (int i = 1; i < seq.size(); i++) step(1'b0, 1'($urandom), 7'($urandom), seq[i]);
        m_ins++;
        step(1'b0, 1'($urandom), 7'($urandom), (m_ins == NI) ? S_PARADA : S_BUSCA);
    endtask

    task automatic run_program(input logic [6:0] op0, input logic [6:0] op1,
                               input logic [6:0] op2, input int n_idle);
        logic [6:0] prog[$];
        prog.push_back(op0);
        prog.push_back(op1);
        prog.push_back(op2);
        step(1'b1, 1'($urandom), 7'($urandom), S_OCIOSO);
        for (int i = 0; i < n_idle; i++) step(1'b0, 1'b0, 7'($urandom), S_OCIOSO);
        step(1'b0, 1'b1, 7'($urandom), S_BUSCA);
        foreach (prog[i]) begin
            if (cur == S_PARADA) break;
            exec_instr(prog[i]);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 7'($urandom), S_PARADA);
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        opcode  = 7'b0;
        cur     = S_OCIOSO;
        m_cyc   = 0;
        m_ins   = 0;
        m_erro  = 1'b0;

        run_program(OP_R, OP_LW, OP_SW, 0);
        run_program(OP_SW, OP_B, OP_I, 2);
        run_program(OP_I, OP_I, OP_I, 1);
        run_program(OP_R, 7'b1111111, OP_R, 0);
        run_program(OP_LW, OP_LW, OP_LW, 0);

        // Reset in the middle of a load.
        step(1'b1, 1'b0, 7'b0, S_OCIOSO);
        step(1'b0, 1'b1, 7'($urandom), S_BUSCA);
        step(1'b0, 1'b0, 7'($urandom), S_DEC);
        step(1'b0, 1'b0, OP_LW, S_CALC);
        step(1'b0, 1'b0, 7'($urandom), S_LE);
        step(1'b1, 1'b1, 7'($urandom), S_OCIOSO);
        step(1'b0, 1'b0, 7'($urandom), S_OCIOSO);

        for (int k = 0; k < 40; k++) begin
            run_program(rand_op(), rand_op(), rand_op(), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
